// File: rtl/window_mac_if.sv
// window_mac_if: control, window-stream and result-stream signals of window_mac.
//   master : drives weightLoad/weightIn, start/accumLen, windowValid/windowIn, resultReady
//   slave  : drives windowReady, busy, resultValid/result, done
// Kernel and window elements are packed with element k at bits [k*DataWidth +: DataWidth].
interface window_mac_if #(
  parameter int unsigned MaxWidth   = 9,
  parameter int unsigned DataWidth  = 8,
  parameter int unsigned AccWidth   = 24,
  parameter int unsigned CountWidth = 8
) ();
  logic                          weightLoad;
  logic [MaxWidth*DataWidth-1:0] weightIn;
  logic                          start;
  logic [CountWidth-1:0]         accumLen;
  logic                          windowValid;
  logic [MaxWidth*DataWidth-1:0] windowIn;
  logic                          windowReady;
  logic                          busy;
  logic                          resultValid;
  logic [AccWidth-1:0]           result;
  logic                          resultReady;
  logic                          done;

  modport master (
    output weightLoad, weightIn, start, accumLen, windowValid, windowIn, resultReady,
    input  windowReady, busy, resultValid, result, done
  );

  modport slave (
    input  weightLoad, weightIn, start, accumLen, windowValid, windowIn, resultReady,
    output windowReady, busy, resultValid, result, done
  );
endinterface

// File: rtl/window_mac.sv
// window_mac: signed dot product of each incoming activation window against a
// locally held kernel, accumulated over accumLen windows (0 treated as 1) and
// presented on a valid/ready result port.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : window_mac_if.slave (kernel load, job start, window stream, result stream)
// Build option: define SATURATE_EN to clamp the accumulator to the signed
// AccWidth range instead of wrapping.
module window_mac #(
  parameter int unsigned MaxWidth   = 9,
  parameter int unsigned DataWidth  = 8,
  parameter int unsigned AccWidth   = 24,
  parameter int unsigned CountWidth = 8
) (
  input  logic         clk,
  input  logic         rst,
  window_mac_if.slave  bus
);
  localparam int unsigned ProdWidth = 2 * DataWidth;
  localparam int unsigned SumWidth  = 2 * DataWidth + $clog2(MaxWidth);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t                          state, state_next;
  logic [MaxWidth*DataWidth-1:0]   kernel, win_q;
  logic [CountWidth-1:0]           len, count;
  logic                            v1, v2, v3;
  logic signed [ProdWidth-1:0]     prod_c [MaxWidth];
  logic signed [ProdWidth-1:0]     prod_q [MaxWidth];
  logic signed [SumWidth-1:0]      sum_c, sum_q;
  logic signed [AccWidth-1:0]      acc, acc_next, result_q;
  logic                            result_valid_q;
  logic                            window_ready, accept, drained, done_c, busy_c;

  function automatic logic signed [ProdWidth-1:0] mul(
    input logic signed [DataWidth-1:0] a,
    input logic signed [DataWidth-1:0] b
  );
    logic signed [ProdWidth-1:0] ae, be;
    ae = ProdWidth'(a);
    be = ProdWidth'(b);
    return ae * be;
  endfunction

  // Stage 1 registers the accepted window; stage 2 holds the products; stage 3
  // holds their sum, which is added into the accumulator on the following edge.
  // A window accepted at edge T therefore lands in the accumulator at T+3.
  always_comb begin
    for (int unsigned k = 0; k < MaxWidth; k++)
      prod_c[k] = mul(win_q[k*DataWidth +: DataWidth], kernel[k*DataWidth +: DataWidth]);
  end

  always_comb begin
    sum_c = '0;
    for (int unsigned k = 0; k < MaxWidth; k++)
      sum_c = sum_c + SumWidth'(prod_q[k]);
  end

`ifdef SATURATE_EN
  logic signed [AccWidth:0] acc_wide;
  always_comb begin
    acc_wide = (AccWidth+1)'(acc) + (AccWidth+1)'(sum_q);
    // One guard bit is enough: |sum| is far below 2^(AccWidth-1).
    if (acc_wide[AccWidth] != acc_wide[AccWidth-1])
      acc_next = acc_wide[AccWidth] ? {1'b1, {(AccWidth-1){1'b0}}}
                                    : {1'b0, {(AccWidth-1){1'b1}}};
    else
      acc_next = acc_wide[AccWidth-1:0];
  end
`else
  always_comb acc_next = acc + AccWidth'(sum_q);
`endif

  assign drained = !v1 && !v2 && !v3;

  always_comb begin
    state_next   = state;
    window_ready = 1'b0;
    busy_c       = 1'b0;
    done_c       = 1'b0;
    unique case (state)
      IDLE: if (bus.start) state_next = RUN;
      RUN: begin
        busy_c       = 1'b1;
        window_ready = (count < len);
        if (bus.windowValid && window_ready && (count + 1'b1) == len)
          state_next = DRAIN;
      end
      DRAIN: begin
        busy_c = 1'b1;
        if (drained) state_next = OUT;
      end
      OUT: begin
        busy_c = 1'b1;
        done_c = bus.resultReady;
        if (bus.resultReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = bus.windowValid && window_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      kernel         <= '0;
      len            <= '0;
      count          <= '0;
      win_q          <= '0;
      v1             <= 1'b0;
      v2             <= 1'b0;
      v3             <= 1'b0;
      prod_q         <= '{default: '0};
      sum_q          <= '0;
      acc            <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state <= state_next;
      v1    <= accept;
      v2    <= v1;
      v3    <= v2;
      if (accept) win_q  <= bus.windowIn;
      if (v1)     prod_q <= prod_c;
      if (v2)     sum_q  <= sum_c;
      if (v3)     acc    <= acc_next;
      unique case (state)
        IDLE: begin
          // Kernel load and start on the same edge: the job sees the new kernel,
          // since no window can be accepted before RUN.
          if (bus.weightLoad) kernel <= bus.weightIn;
          if (bus.start) begin
            len   <= (bus.accumLen == '0) ? CountWidth'(1) : bus.accumLen;
            count <= '0;
            acc   <= '0;
          end
        end
        RUN: if (accept) count <= count + 1'b1;
        DRAIN: if (drained) begin
          result_q       <= acc;
          result_valid_q <= 1'b1;
        end
        OUT: if (bus.resultReady) result_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.windowReady = window_ready;
  assign bus.busy        = busy_c;
  assign bus.resultValid = result_valid_q;
  assign bus.result      = result_q;
  assign bus.done        = done_c;
endmodule

// File: doc/window_mac.md
Name: window_mac

Overview:
- Downstream consumer of the router/buffer memory stage.
- Takes each MaxWidth-element activation window produced by the router and computes a signed dot product against a locally held MaxWidth-element weight kernel.
- Accumulates accumLen consecutive windows into one result, then presents it on a valid/ready output.
- Forms the compute stage between window routing and the output writeback.

Parameters:
- MaxWidth, 9: elements per window and per kernel.
- DataWidth, 8: signed element width (two's complement).
- AccWidth, 24: accumulator and result width.
- CountWidth, 8: width of accumLen and the internal window counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- weightLoad  input  1  latch weightIn into the kernel register; honoured only in IDLE.
- weightIn  input  MaxWidth*DataWidth  kernel; element k at bits [k*DataWidth +: DataWidth].
- start  input  1  begin one accumulation job; honoured only in IDLE.
- accumLen  input  CountWidth  windows per job, sampled on start; 0 is treated as 1.
- windowValid  input  1  windowIn is valid.
- windowIn  input  MaxWidth*DataWidth  activation window, same packing as weightIn.
- windowReady  output  1  window accepted when windowValid && windowReady.
- busy  output  1  high in RUN, DRAIN and OUT.
- resultValid  output  1  result is valid.
- result  output  AccWidth  signed accumulated dot product.
- resultReady  input  1  result consumed when resultValid && resultReady.
- done  output  1  one-cycle pulse on the cycle the result is consumed.

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, kernel register 0, accumulator 0, pipeline valid bits 0, counters 0, state IDLE.
- FSM states: IDLE, RUN, DRAIN, OUT.
- IDLE -> RUN on start:
  - latch len = max(accumLen,1);
  - clear accumulator and accepted-count.
  - start and weightLoad in the same cycle: weights load first, so the job uses the new kernel.
- RUN:
  - windowReady = 1 while accepted-count < len.
  - Each handshake increments accepted-count.
  - At the handshake that makes accepted-count == len, go to DRAIN; windowReady drops the next cycle.
- Pipeline (each stage carries a valid bit):
  - S1: MaxWidth signed products, 2*DataWidth each.
  - S2: signed sum of the products, 2*DataWidth+$clog2(MaxWidth) bits.
  - S3: accumulator += sign-extended sum.
  - A window accepted at edge T is in the accumulator at edge T+3.
- DRAIN: wait until all three pipeline valid bits are 0, then go to OUT; on that entry edge, result = accumulator and resultValid = 1.
- OUT:
  - Hold result and resultValid stable until resultReady.
  - On the handshake: done pulses that cycle, resultValid clears at the next edge, go to IDLE.
  - resultReady may already be high on entry; minimum job-to-idle latency applies then.
- Arithmetic: accumulation wraps modulo 2^AccWidth unless SATURATE_EN is defined.
- Ignored inputs:
  - start while busy.
  - weightLoad outside IDLE.
  - windowValid outside RUN.
- The kernel register persists across jobs until reloaded.
- rst asserted mid-job: immediate abort to the reset state; no result or done is produced.

Optional Feature:
- Macro: SATURATE_EN.
- Defined: the S3 add clamps to the signed range [-2^(AccWidth-1), 2^(AccWidth-1)-1]. Once clamped, the value stays clamped unless later terms bring it back in range. The clamp is evaluated on every add.
- Undefined: plain two's-complement wrap.

Test Plan:
- Kernel all 0x01, accumLen=1, window bytes 0x01..0x09 -> result 0x00002D (45); resultValid appears 4 cycles after the accepting edge; done pulses once.
- Same kernel, accumLen=3, three windows 0x01..0x09 with windowValid gaps of 2 cycles -> result 0x000087 (135); windowReady is 0 after the 3rd handshake.
- Kernel all 0xFF (-1), window all 0x7F, accumLen=1 -> result 0xFFFB89 (-1143).
- Backpressure and ignored inputs:
  - stimulus: hold resultReady=0 for 5 cycles in OUT, pulse start and weightLoad meanwhile;
  - response: result and resultValid stable, no new job, kernel unchanged; after resultReady=1, done pulses and busy=0 the next cycle.
- Overflow:
  - stimulus: kernel all 0x7F, windows all 0x7F, accumLen=255 (per-window sum 145161);
  - response: 0x34D1F7 without SATURATE_EN, 0x7FFFFF with it.
- Reset mid-RUN after 2 of 3 windows -> all outputs 0 asynchronously; a new job after release with accumLen=1 and the reloaded kernel gives the correct result with no residue.
